// File: rtl/fmult_rr_arbiter.sv
// Shares one float_multiplier among NREQ requesters, one operation in flight at a time.
// Define FMULT_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.

module async_rstn_synchronizer (
    input  logic i_CLK,
    input  logic i_RSTN,
    output logic o_RSTN
);

    logic meta;

    // Assert immediately, release two clocks later on i_CLK
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            meta   <= 1'b0;
            o_RSTN <= 1'b0;
        end else begin
            meta   <= 1'b1;
            o_RSTN <= meta;
        end
    end

endmodule

module fmult_rr_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic                 i_CLK,
    input  logic                 i_RSTN,
    input  logic [32*NREQ-1:0]   i_REQ_A,
    input  logic [32*NREQ-1:0]   i_REQ_B,
    input  logic [NREQ-1:0]      i_REQ_STB,
    output logic [NREQ-1:0]      o_REQ_ACK,
    output logic [31:0]          o_Z,
    output logic [NREQ-1:0]      o_Z_STB,
    input  logic [NREQ-1:0]      i_Z_ACK,
    output logic [31:0]          o_M_A,
    output logic [31:0]          o_M_B,
    output logic                 o_M_AB_STB,
    input  logic                 i_M_AB_ACK,
    input  logic [31:0]          i_M_Z,
    input  logic                 i_M_Z_STB,
    output logic                 o_M_Z_ACK
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_Z,
        ST_DELIVER
    } state_t;

    state_t          state;
    logic            w_rstn;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   pick_idx;
    logic            pick_found;
    logic [NREQ-1:0] pick_oh;
    logic [NREQ-1:0] grant_oh;
    logic [31:0]     req_a [NREQ];
    logic [31:0]     req_b [NREQ];

    async_rstn_synchronizer u_rst_sync (
        .i_CLK  (i_CLK),
        .i_RSTN (i_RSTN),
        .o_RSTN (w_rstn)
    );

    for (genvar k = 0; k < NREQ; k++) begin : g_slot
        assign req_a[k] = i_REQ_A[32*k +: 32];
        assign req_b[k] = i_REQ_B[32*k +: 32];
    end

    // First requester found scanning upward from ptr, wrapping at NREQ
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!pick_found && i_REQ_STB[PW'((int'(ptr) + i) % int'(NREQ))]) begin
                pick_found = 1'b1;
                pick_idx   = PW'((int'(ptr) + i) % int'(NREQ));
            end
        end
    end

    assign pick_oh  = NREQ'(1) << pick_idx;
    assign grant_oh = NREQ'(1) << grant_idx;

    always_ff @(posedge i_CLK or negedge w_rstn) begin
        if (!w_rstn) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            grant_idx  <= '0;
            o_REQ_ACK  <= '0;
            o_Z        <= '0;
            o_Z_STB    <= '0;
            o_M_A      <= '0;
            o_M_B      <= '0;
            o_M_AB_STB <= 1'b0;
            o_M_Z_ACK  <= 1'b0;
        end else begin
            o_REQ_ACK <= '0;
            o_M_Z_ACK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_idx  <= pick_idx;
                        o_M_A      <= req_a[pick_idx];
                        o_M_B      <= req_b[pick_idx];
                        o_REQ_ACK  <= pick_oh;
                        o_M_AB_STB <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (o_M_AB_STB && i_M_AB_ACK) begin
                        o_M_AB_STB <= 1'b0;
                        state      <= ST_WAIT_Z;
                    end
                end
                ST_WAIT_Z: begin
                    if (i_M_Z_STB) begin
                        o_Z       <= i_M_Z;
                        o_M_Z_ACK <= 1'b1;
                        o_Z_STB   <= grant_oh;
                        state     <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    // Only the granted requester's ack retires the result
                    if (|(i_Z_ACK & grant_oh)) begin
                        o_Z_STB <= '0;
`ifdef FMULT_ARB_FIXED_PRIO_EN
                        ptr     <= '0;
`else
                        ptr     <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
`endif
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fmult_rr_arbiter.md
FMULT_RR_ARBITER -- requirements
Module: fmult_rr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3 (legal 2..4): number of requesters sharing one float_multiplier.
REQ-002 SHALL have ports i_CLK, input, 1: clock, all logic on posedge.
REQ-003 SHALL have ports i_RSTN, input, 1: reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have ports i_REQ_A, input, 32*NREQ: operand A per requester, slot k = bits [32k+31:32k].
REQ-005 SHALL have ports i_REQ_B, input, 32*NREQ: operand B per requester, same slot layout.
REQ-006 SHALL have ports i_REQ_STB, input, NREQ: requester k operands valid.
REQ-007 SHALL have ports o_REQ_ACK, output, NREQ: one-cycle pulse when requester k's operands are accepted.
REQ-008 SHALL have ports o_Z, output, 32: product returned to the granted requester.
REQ-009 SHALL have ports o_Z_STB, output, NREQ: o_Z valid for requester k.
REQ-010 SHALL have ports i_Z_ACK, input, NREQ: requester k has taken o_Z.
REQ-011 SHALL have ports o_M_A, o_M_B, output, 32 each: multiplier operands.
REQ-012 SHALL have ports o_M_AB_STB, output, 1, and i_M_AB_ACK, input, 1: multiplier operand handshake.
REQ-013 SHALL have ports i_M_Z, input, 32, i_M_Z_STB, input, 1, o_M_Z_ACK, output, 1: multiplier result handshake.

Function
REQ-014 SHALL implement states ST_IDLE, ST_ISSUE, ST_WAIT_Z, ST_DELIVER; only one operation outstanding at any time.
REQ-015 ST_IDLE: any i_REQ_STB bit set -> pick winner w, latch slot w A/B into o_M_A/o_M_B, register o_REQ_ACK[w]=1 for exactly one cycle, o_M_AB_STB=1, go ST_ISSUE; ACK visible the cycle after STB first seen.
REQ-016 Round-robin: search starts at index ptr, ascending, wrapping NREQ-1 -> 0; first set bit wins.
REQ-017 ptr SHALL update to (w+1) mod NREQ when the operation completes in ST_DELIVER.
REQ-018 ST_ISSUE: hold o_M_AB_STB=1 and operands stable until o_M_AB_STB & i_M_AB_ACK in the same cycle; then deassert o_M_AB_STB next cycle, go ST_WAIT_Z.
REQ-019 ST_WAIT_Z: on i_M_Z_STB capture i_M_Z into o_Z, pulse o_M_Z_ACK one cycle, go ST_DELIVER.
REQ-020 ST_DELIVER: hold o_Z_STB[w]=1, o_Z stable, until i_Z_ACK[w]=1; then clear o_Z_STB, return ST_IDLE.
REQ-021 i_Z_ACK of non-granted requesters and i_REQ_STB changes after grant SHALL be ignored; operands are latched, not re-sampled.
REQ-022 A requester holding STB through ST_DELIVER SHALL be rearbitrated normally in the following ST_IDLE (no double accept within one op).
REQ-023 Minimum turnaround with zero-latency multiplier and immediate acks: 4 cycles per operation; no idle cycle needed between back-to-back operations beyond ST_IDLE.
REQ-024 At most one bit of o_REQ_ACK and of o_Z_STB SHALL be set in any cycle.

Reset
REQ-025 i_RSTN low SHALL asynchronously force: state ST_IDLE, ptr 0, o_REQ_ACK 0, o_Z 0, o_Z_STB 0, o_M_A 0, o_M_B 0, o_M_AB_STB 0, o_M_Z_ACK 0.
REQ-026 Reset mid-operation SHALL abandon the operation; no result delivered after release; first post-reset grant uses ptr 0.
REQ-027 Release SHALL pass through async_rstn_synchronizer so deassertion is synchronous to i_CLK.

Configuration
REQ-028 Macro FMULT_ARB_FIXED_PRIO_EN defined: fixed priority, lowest set index always wins, ptr unused and held 0.
REQ-029 Macro undefined: round-robin per REQ-016/017.

Verification
REQ-030 Single req: slot0 A=0x40000000, B=0x40400000 -> o_REQ_ACK[0] one pulse, o_Z=0x40C00000 with o_Z_STB[0] until i_Z_ACK[0].
REQ-031 All three STB held continuously, RR build -> grant order 0,1,2,0,1,2; fixed-prio build -> 0 only until slot0 drops.
REQ-032 Multiplier holds i_M_AB_ACK low 5 cycles -> o_M_AB_STB and o_M_A/B stable for all 5, transfer on cycle 6.
REQ-033 i_Z_ACK[1] asserted while granted to 0 -> ignored; o_Z_STB[0] stays high until i_Z_ACK[0].
REQ-034 i_RSTN low during ST_WAIT_Z -> all outputs 0 same cycle; late i_M_Z_STB after release ignored; next request slot2 only granted normally.
REQ-035 Slot1 A=0xC0000000, B=0x3F000000 -> o_Z=0xBF800000; operands changed after ACK do not affect result.
